// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared CPU definitions used by the iterative divider.
//   Contents:
//     DIV_WIDTH          default operand/result width
//     STEP_W             width of the shift-subtract step counter
//     DIV_ZERO_QUOTIENT  quotient pattern written to LO on divide-by-zero
//                        (sliced to the operand width by the user)
//     div_state_t        divider FSM state encoding
// -----------------------------------------------------------------------------
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int STEP_W    = 5;

    // Divide-by-zero produces an all-ones quotient. Held at 64 bits so any
    // operand width up to 64 can take its low slice.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        RUN     = 2'd2,
        DONE    = 2'd3
    } div_state_t;

endpackage : divider_pkg

// File: rtl/divider_div_step.sv
// -----------------------------------------------------------------------------
// div_step
//   One restoring shift-subtract step of an unsigned division.
//   Ports:
//     rem       current partial remainder (always < dvs)
//     bit_in    next dividend bit shifted into the partial remainder
//     dvs       divisor magnitude (non-zero)
//     rem_next  partial remainder after this step
//     q_bit     quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dvs on entry, so the shifted value is < 2*dvs and fits WIDTH+1
    // bits; the top bit of the difference is therefore a clean borrow flag.
    assign shifted  = {rem, bit_in};
    assign diff     = shifted - {1'b0, dvs};
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule : div_step

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Multi-cycle DIV/DIVU unit for the HI/LO register pair. Signed operands are
//   converted to magnitudes, divided by a restoring shift-subtract loop (one
//   step per clock), and the signs are fixed up on the final step.
//
//   Handshake: start is a request sampled only while the unit is idle (busy=0,
//   state IDLE) and cancel=0; signed_op, dividend and divisor are captured on
//   that same edge. busy stays high until the result is ready; result_valid is
//   a single-cycle strobe with hi/lo already carrying the new result. There is
//   no back-pressure on the result. cancel aborts any operation in progress
//   and the unit returns to IDLE without producing a result.
//
//   Ports:
//     clock         system clock, rising edge
//     reset         asynchronous active-low reset
//     start         request to begin a division
//     signed_op     1 = DIV (two's complement), 0 = DIVU
//     cancel        pipeline flush, aborts any operation in progress
//     dividend      rs operand
//     divisor       rt operand
//     busy          pipeline stall request while an operation runs
//     result_valid  one-cycle HI/LO write enable
//     hi            remainder
//     lo            quotient
//     state         current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic             cancel,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output div_state_t       state
);

    // Working registers. quo starts as the dividend magnitude and is shifted
    // left each step: its MSB feeds the remainder, quotient bits enter at LSB.
    // On the divide-by-zero path quo holds the raw dividend bit pattern.
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [WIDTH-1:0]  dvs;
    logic [STEP_W-1:0] step;
    logic              neg_q;
    logic              neg_r;

    logic              accept;
    logic              last_step;
    logic [WIDTH-1:0]  dividend_mag;
    logic [WIDTH-1:0]  divisor_mag;
    logic [WIDTH-1:0]  step_rem;
    logic              step_q;
    logic [WIDTH-1:0]  quo_next;
    logic [WIDTH-1:0]  final_q;
    logic [WIDTH-1:0]  final_r;

    assign accept    = start && !cancel;
    assign last_step = (step == STEP_W'(WIDTH - 1));

    // Magnitudes: in signed mode a negative operand is negated. The most
    // negative value maps to itself, which is its correct unsigned magnitude.
    assign dividend_mag = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem),
        .bit_in   (quo[WIDTH-1]),
        .dvs      (dvs),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    assign quo_next = {quo[WIDTH-2:0], step_q};

    // Sign fix-up applied on the last step. Quotient negation wraps, so
    // most-negative / -1 yields the most-negative value without trapping.
    assign final_q = neg_q ? -quo_next : quo_next;
    assign final_r = neg_r ? -step_rem : step_rem;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            step         <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            hi           <= '0;
            lo           <= '0;
            rem          <= '0;
            quo          <= '0;
            dvs          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
        end else begin
            // result_valid is a strobe; only the transition into DONE sets it.
            result_valid <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (accept) begin
                        step  <= '0;
                        rem   <= '0;
                        dvs   <= divisor_mag;
                        neg_q <= signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_r <= signed_op && dividend[WIDTH-1];
                        busy  <= 1'b1;
                        if (divisor == '0) begin
                            quo   <= dividend;
                            state <= BY_ZERO;
                        end else begin
                            quo   <= dividend_mag;
                            state <= RUN;
                        end
                    end
                end

                BY_ZERO: begin
                    busy <= 1'b0;
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        lo           <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
                        hi           <= quo;
                        result_valid <= 1'b1;
                        state        <= DONE;
                    end
                end

                RUN: begin
                    if (cancel) begin
                        busy  <= 1'b0;
                        step  <= '0;
                        state <= IDLE;
                    end else begin
                        rem  <= step_rem;
                        quo  <= quo_next;
                        step <= step + 1'b1;
                        if (last_step) begin
                            busy         <= 1'b0;
                            lo           <= final_q;
                            hi           <= final_r;
                            result_valid <= 1'b1;
                            step         <= '0;
                            state        <= DONE;
                        end
                    end
                end

                DONE: begin
                    // The result was already written on entry; cancel and
                    // start have nothing left to affect here.
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : divider

// File: tb/tb_divider.sv
module tb_divider;
    import divider_pkg::*;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         start;
    logic         signed_op;
    logic         cancel;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         result_valid;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    div_state_t   state;

    int tests_run;
    int tests_failed;

    divider #(
        .WIDTH (W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .signed_op    (signed_op),
        .cancel       (cancel),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo),
        .state        (state)
    );

    // ---------------------------------------------------------------- clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- check
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver
    // Issues one operation and follows it to its result strobe. Inputs change
    // on the falling edge; outputs are sampled on the falling edge, i.e. in the
    // middle of each cycle. Cycle n is the cycle after rising edge n, with the
    // start sampled at edge 0.
    task automatic do_op(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_bad,
                         output logic [W-1:0] rlo, output logic [W-1:0] rhi);
        int cyc;
        lat      = -1;
        busy_bad = 0;
        rlo      = '0;
        rhi      = '0;
        @(negedge clock);
        start     = 1'b1;
        signed_op = sgn;
        dividend  = a;
        divisor   = b;
        @(negedge clock);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 100) begin
            if (result_valid) begin
                lat = cyc;
                rlo = lo;
                rhi = hi;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge clock);
            cyc++;
        end
    endtask

    // ---------------------------------------------------------------- vectors
    typedef struct {
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_lo;
        logic [W-1:0] exp_hi;
        int           exp_lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int           lat;
        int           busy_bad;
        int           cnt;
        logic [W-1:0] rlo;
        logic [W-1:0] rhi;
        logic [W-1:0] keep_lo;
        logic [W-1:0] keep_hi;

        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 33};
        vecs[2]  = '{1'b1, 32'h12345678,   32'h0,          32'hFFFFFFFF, 32'h12345678, 2};
        vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
        vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF, 32'h00000000, 33};
        vecs[5]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC, 32'h00000001, 33};
        vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
        vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF, 33};
        vecs[8]  = '{1'b0, 32'd5,          32'h0,          32'hFFFFFFFF, 32'h00000005, 2};
        vecs[9]  = '{1'b0, 32'd3,          32'd10,         32'h00000000, 32'h00000003, 33};
        vecs[10] = '{1'b1, 32'h80000000,   32'd1,          32'h80000000, 32'h00000000, 33};
        vecs[11] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000, 32'h80000000, 33};
        vecs[12] = '{1'b1, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
        vecs[13] = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2, 32'hFFFFFFFE, 33};

        // ------------------------------------------------ reset
        reset     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        cancel    = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #1;
        check("reset_busy",  W'(busy), '0);
        check("reset_valid", W'(result_valid), '0);
        check("reset_hi",    hi, '0);
        check("reset_lo",    lo, '0);
        check("reset_state", W'(state), W'(IDLE));
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // ------------------------------------------------ table
        for (int i = 0; i < 14; i++) begin
            do_op(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, busy_bad, rlo, rhi);
            check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].exp_lat));
            check($sformatf("v%0d_lo", i), rlo, vecs[i].exp_lo);
            check($sformatf("v%0d_hi", i), rhi, vecs[i].exp_hi);
            check($sformatf("v%0d_busy", i), W'(busy_bad), '0);
            @(negedge clock);
            check($sformatf("v%0d_strobe_end", i), W'(result_valid), '0);
            check($sformatf("v%0d_hold_lo", i), lo, vecs[i].exp_lo);
            check($sformatf("v%0d_hold_hi", i), hi, vecs[i].exp_hi);
        end
        keep_lo = 32'hFFFFFFF2;
        keep_hi = 32'hFFFFFFFE;

        // ------------------------------------------------ start with cancel=1 ignored
        @(negedge clock);
        start    = 1'b1;
        cancel   = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clock);
        start  = 1'b0;
        cancel = 1'b0;
        check("start_cancel_busy",  W'(busy), '0);
        check("start_cancel_state", W'(state), W'(IDLE));

        // ------------------------------------------------ cancel in RUN cycle 10
        @(negedge clock);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clock);
        check("cancel_run_busy_before", W'(busy), 32'd1);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        check("cancel_run_busy",   W'(busy), '0);
        check("cancel_run_valid1", W'(result_valid), '0);
        @(negedge clock);
        check("cancel_run_valid2", W'(result_valid), '0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid || busy) cnt++;
            @(negedge clock);
        end
        check("cancel_run_quiet", W'(cnt), '0);
        check("cancel_run_lo", lo, keep_lo);
        check("cancel_run_hi", hi, keep_hi);

        do_op(1'b0, 32'd9, 32'd3, lat, busy_bad, rlo, rhi);
        check("after_cancel_latency", W'(lat), 32'd33);
        check("after_cancel_lo", rlo, 32'd3);
        check("after_cancel_hi", rhi, 32'd0);
        keep_lo = 32'd3;
        keep_hi = 32'd0;

        // ------------------------------------------------ cancel in BY_ZERO
        @(negedge clock);
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'hCAFEF00D;
        divisor   = 32'h0;
        @(negedge clock);
        start = 1'b0;
        check("byzero_busy", W'(busy), 32'd1);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        check("cancel_bz_valid1", W'(result_valid), '0);
        check("cancel_bz_busy",   W'(busy), '0);
        @(negedge clock);
        check("cancel_bz_valid2", W'(result_valid), '0);
        check("cancel_bz_lo", lo, keep_lo);
        check("cancel_bz_hi", hi, keep_hi);

        // ------------------------------------------------ start while RUN ignored
        @(negedge clock);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd10;
        @(negedge clock);
        dividend  = 32'd77;
        divisor   = 32'd0;
        for (int c = 1; c < 4; c++) @(negedge clock);
        start = 1'b0;
        cnt   = 4;
        while (!result_valid && cnt < 100) begin
            @(negedge clock);
            cnt++;
        end
        check("busy_start_latency", W'(cnt), 32'd33);
        check("busy_start_lo", lo, 32'd100);
        check("busy_start_hi", hi, 32'd0);
        @(negedge clock);
        check("busy_start_idle", W'(busy), '0);

        // ------------------------------------------------ reset in RUN cycle 5
        @(negedge clock);
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd12345;
        divisor   = 32'd11;
        @(negedge clock);
        start = 1'b0;
        for (int c = 1; c < 5; c++) @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("rst_run_busy",  W'(busy), '0);
        check("rst_run_valid", W'(result_valid), '0);
        check("rst_run_hi",    hi, '0);
        check("rst_run_lo",    lo, '0);
        check("rst_run_state", W'(state), W'(IDLE));
        @(negedge clock);
        reset = 1'b1;
        cnt   = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (result_valid || busy) cnt++;
        end
        check("rst_no_resume", W'(cnt), '0);
        check("rst_no_resume_lo", lo, '0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Absolute time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule : tb_divider
